// File: rtl/mips_dump_pkg.sv
// -----------------------------------------------------------------------------
// mips_dump_pkg
// Shared definitions for the MIPS state dump block:
//   dump_state_e : FSM state encoding (also exposed on the debug port)
//   TAG_*        : beat tag codes carried on out_tag
//   NUM_REGS     : register-file depth walked by the dump
// Optional feature macro: MIPS_DUMP_CHECKSUM_EN (adds the CSUM state).
// -----------------------------------------------------------------------------
package mips_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REGS = 3'd1,
    ST_MEM  = 3'd2,
`ifdef MIPS_DUMP_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_FIN  = 3'd4
  } dump_state_e;

  localparam logic [1:0] TAG_REG  = 2'b00;
  localparam logic [1:0] TAG_MEM  = 2'b01;
  localparam logic [1:0] TAG_CSUM = 2'b10;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/mips_state_dump_if.sv
// -----------------------------------------------------------------------------
// mips_dump_stream_if
// Word stream carrying dumped words out of the dump engine.
//   valid/ready handshake: a beat transfers on every rising edge where both
//   valid and ready are high. Once valid is raised, valid, data, tag and index
//   hold steady until that transfer; ready may toggle freely and never gates
//   valid.
// Signals: valid, ready, data[31:0], tag[1:0], index[MEM_AW-1:0]
// Modports: master (drives the beat), slave (accepts the beat)
// -----------------------------------------------------------------------------
interface mips_dump_stream_if #(
  parameter int MEM_AW = 8
);
  logic              valid;
  logic              ready;
  logic [31:0]       data;
  logic [1:0]        tag;
  logic [MEM_AW-1:0] index;

  modport master (output valid, output data, output tag, output index, input ready);
  modport slave  (input valid, input data, input tag, input index, output ready);
endinterface

// File: rtl/dump_out_stage.sv
// -----------------------------------------------------------------------------
// dump_out_stage
// Single-entry output holding register with valid/ready toward the sink.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   i_load         : capture i_data/i_tag/i_index this cycle (only when o_can_load)
//   o_can_load     : register empty, or its word is being accepted this cycle
//   o_empty        : nothing held
//   stream         : master side of the output word stream
// -----------------------------------------------------------------------------
module dump_out_stage #(
  parameter int MEM_AW = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [31:0]       i_data,
  input  logic [1:0]        i_tag,
  input  logic [MEM_AW-1:0] i_index,
  output logic              o_can_load,
  output logic              o_empty,
  mips_dump_stream_if.master stream
);

  logic              r_valid;
  logic [31:0]       r_data;
  logic [1:0]        r_tag;
  logic [MEM_AW-1:0] r_index;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_index <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_tag   <= i_tag;
      r_index <= i_index;
    end else if (stream.ready) begin
      r_valid <= 1'b0;
    end
  end

  // Refill in the same cycle the held word drains, so a ready sink sees
  // one word per cycle.
  assign o_can_load   = !r_valid || stream.ready;
  assign o_empty      = !r_valid;

  assign stream.valid = r_valid;
  assign stream.data  = r_data;
  assign stream.tag   = r_tag;
  assign stream.index = r_index;

endmodule

// File: rtl/mips_state_dump.sv
// -----------------------------------------------------------------------------
// mips_state_dump
// Walks the 32-entry register file, then DATA_WORDS data-memory words, and
// streams each word out with a tag and index. Optional checksum beat when
// MIPS_DUMP_CHECKSUM_EN is defined (XOR of every register and memory word).
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   start                  : one-cycle dump request (honoured only when idle)
//   busy, done             : dump in progress / one-cycle completion pulse
//   reg_addr, reg_rdata    : register-file read port (combinational data)
//   mem_addr, mem_rdata    : data-memory read port (combinational data)
//   out_valid, out_ready   : output word handshake
//   out_data/out_tag/out_index : dumped word, tag (00 reg, 01 mem, 10 csum), index
//   dbg_state              : current FSM state
// -----------------------------------------------------------------------------
module mips_state_dump
  import mips_dump_pkg::*;
#(
  parameter int DATA_WORDS = 256,
  parameter int MEM_AW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [1:0]        out_tag,
  output logic [MEM_AW-1:0] out_index,
  output dump_state_e       dbg_state
);

  // Counter must cover both register numbers (0..31) and memory indices.
  localparam int CW = (MEM_AW > 5) ? MEM_AW : 5;
  localparam logic [CW-1:0] LAST_REG = CW'(NUM_REGS - 1);
  localparam logic [CW-1:0] LAST_MEM = CW'(DATA_WORDS - 1);

  dump_state_e r_state;
  logic [CW-1:0] r_cnt;

  logic              w_can_load;
  logic              w_empty;
  logic              w_load;
  logic [31:0]       w_data;
  logic [1:0]        w_tag;
  logic [MEM_AW-1:0] w_index;

`ifdef MIPS_DUMP_CHECKSUM_EN
  logic [31:0] r_csum;
`endif

  mips_dump_stream_if #(.MEM_AW(MEM_AW)) u_stream ();

  dump_out_stage #(.MEM_AW(MEM_AW)) u_out (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_data),
    .i_tag      (w_tag),
    .i_index    (w_index),
    .o_can_load (w_can_load),
    .o_empty    (w_empty),
    .stream     (u_stream)
  );

  assign u_stream.ready = out_ready;
  assign out_valid      = u_stream.valid;
  assign out_data       = u_stream.data;
  assign out_tag        = u_stream.tag;
  assign out_index      = u_stream.index;

  // Select the word offered to the output stage for the current state.
  always_comb begin
    w_load  = 1'b0;
    w_data  = '0;
    w_tag   = TAG_REG;
    w_index = '0;
    case (r_state)
      ST_REGS: begin
        w_load  = w_can_load;
        w_data  = reg_rdata;
        w_tag   = TAG_REG;
        w_index = MEM_AW'(r_cnt);
      end
      ST_MEM: begin
        w_load  = w_can_load;
        w_data  = mem_rdata;
        w_tag   = TAG_MEM;
        w_index = MEM_AW'(r_cnt);
      end
`ifdef MIPS_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        w_load  = w_can_load;
        w_data  = r_csum;
        w_tag   = TAG_CSUM;
        w_index = '0;
      end
`endif
      default: ;
    endcase
  end

  // Counter only moves on capture, so a stalled sink freezes the read address.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_state <= ST_REGS;
          end
        end
        ST_REGS: begin
          if (w_load) begin
            if (r_cnt == LAST_REG) begin
              r_cnt   <= '0;
              r_state <= ST_MEM;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_MEM: begin
          if (w_load) begin
            if (r_cnt == LAST_MEM) begin
              r_cnt <= '0;
`ifdef MIPS_DUMP_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_FIN;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
`ifdef MIPS_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_load) r_state <= ST_FIN;
        end
`endif
        ST_FIN: begin
          if (w_empty) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MIPS_DUMP_CHECKSUM_EN
  // Every captured register/memory word is eventually emitted, so folding
  // at capture time equals folding at emission.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_csum <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_csum <= '0;
    end else if ((r_state == ST_REGS || r_state == ST_MEM) && w_load) begin
      r_csum <= r_csum ^ w_data;
    end
  end
`endif

  // done fires in the FIN cycle where the last word has left; busy drops
  // in that same cycle.
  assign done      = (r_state == ST_FIN) && w_empty;
  assign busy      = (r_state != ST_IDLE) && !done;
  assign reg_addr  = r_cnt[4:0];
  assign mem_addr  = r_cnt[MEM_AW-1:0];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_state_dump.sv
// -----------------------------------------------------------------------------
// tb_mips_state_dump
// Bench for mips_state_dump (DATA_WORDS=4, MEM_AW=8). A behavioural model
// builds the full expected beat list when a start is accepted; one compare
// process checks busy/done/stream against it every cycle.
// Honours MIPS_DUMP_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mips_state_dump;
  import mips_dump_pkg::*;

  localparam int DW = 4;
  localparam int AW = 8;
`ifdef MIPS_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB = 32 + DW + CS;
  localparam int BW = 2 + AW + 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  logic start;
  always #5 clock = ~clock;

  mips_dump_stream_if #(.MEM_AW(AW)) sink_if ();

  logic          busy, done;
  logic [4:0]    reg_addr;
  logic [31:0]   reg_rdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  dump_state_e   dbg_state;

  logic [31:0] rf[32];
  logic [31:0] dm[DW];

  assign reg_rdata = rf[reg_addr];
  assign mem_rdata = (mem_addr < AW'(DW)) ? dm[mem_addr[1:0]] : 32'hDEAD_BEEF;

  mips_state_dump #(.DATA_WORDS(DW), .MEM_AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (sink_if.valid),
    .out_ready (sink_if.ready),
    .out_data  (sink_if.data),
    .out_tag   (sink_if.tag),
    .out_index (sink_if.index),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / model
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_log[$];
  bit  chk_en = 0;
  bit  m_busy = 0;
  bit  m_done = 0;
  bit  prev_stall = 0;
  logic [BW-1:0] prev_beat;
  int  cyc = 0, beat_cnt = 0, done_cnt = 0, acc_cyc = 0, done_cyc = 0;

  function automatic void build_expected();
    logic [31:0] csum;
    csum = '0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({TAG_REG, AW'(i), rf[i]});
      csum ^= rf[i];
    end
    for (int j = 0; j < DW; j++) begin
      exp_q.push_back({TAG_MEM, AW'(j), dm[j]});
      csum ^= dm[j];
    end
    if (CS == 1) exp_q.push_back({TAG_CSUM, AW'(0), csum});
  endfunction

  always @(negedge clock) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] e;
    logic hs;
    cyc++;
    cur = {sink_if.tag, sink_if.index, sink_if.data};
    hs  = (sink_if.valid === 1'b1) && (sink_if.ready === 1'b1);
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      if (!m_busy) check("valid_when_idle", sink_if.valid, 1'b0);
      if (prev_stall) begin
        check("stall_valid", sink_if.valid, 1'b1);
        check("stall_beat", cur, prev_beat);
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_beat: got 0x%0h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        got_log.push_back(cur);
        beat_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    // advance the model to the next cycle
    prev_stall = (sink_if.valid === 1'b1) && (sink_if.ready !== 1'b1) && !reset;
    prev_beat  = cur;
    if (reset) begin
      m_busy = 0;
      m_done = 0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy && start) begin
      m_busy = 1;
      build_expected();
      acc_cyc  = cyc;
      beat_cnt = 0;
      got_log.delete();
    end else if (m_busy && hs && exp_q.size() == 0) begin
      m_busy = 0;
      m_done = 1;
    end
  end

  // driver tasks
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random

  initial begin
    sink_if.ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       sink_if.ready = 1'b1;
        1:       sink_if.ready = ~sink_if.ready;
        default: sink_if.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic pulse_start();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: got no done within %0d cycles expected done", budget);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic wait_beats(input int nb, input int budget);
    int n;
    n = 0;
    while (beat_cnt < nb && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (beat_cnt < nb) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_beats: got %0d beats expected %0d", beat_cnt, nb);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    for (int j = 0; j < DW; j++) dm[j] = 32'(j + 'h100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, n, ntag2;
    reset = 1'b1;
    start = 1'b0;
    fill_pattern();
    repeat (3) @(posedge clock);
    #1;
    // reset values
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", sink_if.valid, 1'b0);
    check("rst_data", sink_if.data, 32'h0);
    check("rst_tag", sink_if.tag, 2'b00);
    check("rst_index", sink_if.index, 8'h0);
    check("rst_reg_addr", reg_addr, 5'h0);
    check("rst_mem_addr", mem_addr, 8'h0);
    reset  = 1'b0;
    chk_en = 1;

    // ready held high: back-to-back beats, fixed latency
    ready_mode = 0;
    pulse_start();
    wait_done(300);
    check("t1_latency", 64'(done_cyc - acc_cyc), 64'(38 + CS));
    check("t1_beats", 64'(got_log.size()), 64'(NB));
    check("t1_reg0", got_log[0], {TAG_REG, 8'd0, 32'd0});
    check("t1_reg31", got_log[31], {TAG_REG, 8'd31, 32'd93});
    check("t1_mem0", got_log[32], {TAG_MEM, 8'd0, 32'h100});
    check("t1_mem3", got_log[35], {TAG_MEM, 8'd3, 32'h103});

    // ready toggling each cycle
    ready_mode = 1;
    pulse_start();
    wait_done(600);
    check("t2_beats", 64'(got_log.size()), 64'(NB));

    // start while busy and in the done cycle must be ignored
    ready_mode = 2;
    dc0 = done_cnt;
    pulse_start();
    wait_beats(10, 600);
    pulse_start();
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(posedge clock); #1; n++;
    end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("t3_single_done", 64'(done_cnt - dc0), 64'd1);
    check("t3_beats", 64'(got_log.size()), 64'(NB));
    check("t3_idle_after", busy, 1'b0);

    // reset mid-dump, then a clean dump from reg 0
    pulse_start();
    wait_beats(20, 600);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check("t4_busy_after_rst", busy, 1'b0);
    check("t4_valid_after_rst", sink_if.valid, 1'b0);
    pulse_start();
    wait_done(600);
    check("t4_beats", 64'(got_log.size()), 64'(NB));
    check("t4_first", got_log[0], {TAG_REG, 8'd0, 32'd0});

    // checksum pattern
    ready_mode = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    dm[0] = 32'hF0F0_F0F0;
    dm[1] = 32'h0F0F_0F0F;
    dm[2] = 32'h0;
    dm[3] = 32'h0;
    pulse_start();
    wait_done(300);
    check("t5_beats", 64'(got_log.size()), 64'(NB));
`ifdef MIPS_DUMP_CHECKSUM_EN
    check("t5_csum_beat", got_log[36], {TAG_CSUM, 8'd0, 32'hFFFF_FFFF});
`else
    ntag2 = 0;
    for (int i = 0; i < got_log.size(); i++)
      if (got_log[i][BW-1 -: 2] == TAG_CSUM) ntag2++;
    check("t5_no_csum_tag", 64'(ntag2), 64'd0);
`endif

    // random contents, random sink
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int j = 0; j < DW; j++) dm[j] = $urandom;
      pulse_start();
      wait_done(600);
      check("t6_beats", 64'(got_log.size()), 64'(NB));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_state_dump.md
MIPS_STATE_DUMP -- requirements
Module: mips_state_dump

Interface
REQ-001 SHALL have parameter DATA_WORDS, default 256, number of data-memory words dumped.
REQ-002 SHALL have parameter MEM_AW, default 8, data-memory word-address width (2**MEM_AW >= DATA_WORDS).
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port busy  output  1  high from accepted start until final word handshaken.
REQ-007 SHALL have port done  output  1  one-cycle pulse after final word handshaken.
REQ-008 SHALL have port reg_addr  output  5  register-file read address.
REQ-009 SHALL have port reg_rdata  input  32  register-file combinational read data.
REQ-010 SHALL have port mem_addr  output  MEM_AW  data-memory word read address.
REQ-011 SHALL have port mem_rdata  input  32  data-memory combinational read data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_tag/out_index valid.
REQ-013 SHALL have port out_ready  input  1  sink accepts word when high with out_valid.
REQ-014 SHALL have port out_data  output  32  dumped word.
REQ-015 SHALL have port out_tag  output  2  00 register, 01 memory, 10 checksum.
REQ-016 SHALL have port out_index  output  MEM_AW  register number or memory word index (0 for checksum).

Function
REQ-017 SHALL implement FSM IDLE -> REGS -> MEM -> (CSUM) -> FIN -> IDLE.
REQ-018 IDLE: start=1 SHALL clear index counter to 0 and enter REGS next cycle; start SHALL be ignored in all other states.
REQ-019 REGS: SHALL drive reg_addr=counter, capture reg_rdata into single-entry output register when empty or being drained same cycle; after index 31 captured, SHALL reset counter to 0 and enter MEM.
REQ-020 MEM: SHALL drive mem_addr=counter, capture mem_rdata likewise; after index DATA_WORDS-1 captured, SHALL enter CSUM (macro on) or FIN.
REQ-021 Capture-to-out_valid latency SHALL be one cycle; with out_ready held high, one word SHALL be emitted per cycle (32+DATA_WORDS consecutive beats, +1 with checksum).
REQ-022 out_valid SHALL stay high and out_data/out_tag/out_index SHALL remain stable until out_ready=1.
REQ-023 Counter SHALL advance only on capture; out_ready low SHALL stall reads without skipping or duplicating any index.
REQ-024 FIN: SHALL wait until output register empty, then pulse done for exactly one cycle, drop busy same cycle, return to IDLE.
REQ-025 start asserted in the done cycle SHALL be ignored.

Reset
REQ-026 reset SHALL force IDLE, counter 0, output register empty, checksum 0, at next rising edge, including mid-dump.
REQ-027 Reset values: busy=0, done=0, out_valid=0, out_data=0, out_tag=00, out_index=0, reg_addr=0, mem_addr=0.

Configuration
REQ-028 With macro MIPS_DUMP_CHECKSUM_EN defined, SHALL XOR-accumulate every emitted register and memory word and emit one final beat tag 10, out_data=accumulator, cleared on accepted start.
REQ-029 Without MIPS_DUMP_CHECKSUM_EN, CSUM state and accumulator SHALL be absent and MEM SHALL go directly to FIN.

Structure
REQ-030 Package mips_dump_pkg SHALL hold FSM state enum and tag constants TAG_REG, TAG_MEM, TAG_CSUM.
REQ-031 Output holding register with valid/ready SHALL be sub-module dump_out_stage; FSM and counter stay in mips_state_dump.

Verification
REQ-032 reg file r[i]=i*3, mem[j]=j+0x100, DATA_WORDS=4, out_ready=1, start pulse -> 36 beats: reg 0..31 data 0..93 then mem 0..3 data 0x100..0x103, done one cycle after last beat.
REQ-033 Same stimulus, out_ready toggled 1/0 each cycle -> identical beat sequence, no gaps/duplicates, outputs stable while stalled.
REQ-034 start pulsed again at beat 10 and in done cycle -> no restart, sequence unchanged, single done.
REQ-035 reset asserted at beat 20 -> next cycle busy=0, out_valid=0; fresh start dumps from reg 0.
REQ-036 MIPS_DUMP_CHECKSUM_EN defined, all regs 0, mem={0xF0F0F0F0,0x0F0F0F0F,0,0} -> final beat tag 10 data 0xFFFFFFFF.
REQ-037 Macro undefined, same stimulus -> 36 beats, no tag-10 beat.
